// File: rtl/latch_checker_if.sv
// latch_checker_if
//   Bundle between the latch checker and the latch cells it exercises.
//   Ports (as signals of the bundle):
//     D    - data broadcast to every lane (driven by the checker)
//     en   - enable broadcast to every lane (driven by the checker)
//     Q    - per-lane true outputs of the latches under test
//     Q_n  - per-lane complement outputs of the latches under test
//   Modports:
//     master - the checker side (drives D/en, observes Q/Q_n)
//     slave  - the latch side (observes D/en, drives Q/Q_n)
interface latch_checker_if #(
  parameter int LANES = 4
);
  logic             D;
  logic             en;
  logic [LANES-1:0] Q;
  logic [LANES-1:0] Q_n;

  modport master (output D, output en, input Q, input Q_n);
  modport slave  (input D, input en, output Q, output Q_n);
endinterface

// File: rtl/latch_checker.sv
// latch_checker
//   Self-checking exerciser for gated D-latches. A short init sequence forces
//   every lane to 0, then pseudo-random D/en vectors from an 8-bit LFSR are
//   broadcast to all lanes. After a settle window each lane's Q/Q_n is compared
//   with a golden model that knows whether the lane is positive-level
//   (transparent on en=1) or negative-level (transparent on en=0).
//
//   Ports:
//     clk       - rising-edge clock
//     rst_n     - synchronous active-low reset
//     start     - run request, honoured only in IDLE or DONE
//     lat       - latch bundle (master): D, en out; Q, Q_n in
//     busy      - run in progress
//     done      - run finished, results valid
//     pass      - valid with done; 1 iff no vector failed
//     err_count - failing vectors, saturating at 255
//     err_lane  - sticky per-lane mismatch flags for the current run
//     vec_idx   - index of the vector currently applied
//
//   busy/done/pass are registered from the state, so they trail the state
//   register by one cycle; this is the final +1 of the start-to-done latency.
//
//   Optional feature (macro LATCH_CHK_SYNC_EN): Q and Q_n pass through
//   two-flop synchronizers before comparison and the settle window is
//   stretched by two cycles to absorb the synchronizer delay.
module latch_checker #(
  parameter int               LANES         = 4,
  parameter logic [LANES-1:0] NEG_MASK      = LANES'(4'b1100),
  parameter int               NUM_VECTORS   = 16,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [7:0]       SEED          = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  latch_checker_if.master      lat,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [LANES-1:0]     err_lane,
  output logic [9:0]           vec_idx
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

`ifdef LATCH_CHK_SYNC_EN
  localparam int WAIT_LEN = SETTLE_CYCLES + 2;
`else
  localparam int WAIT_LEN = SETTLE_CYCLES;
`endif

  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WAIT_END   = 16'(WAIT_LEN - 1);
  localparam logic [9:0]  LAST_IDX   = 10'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_HI,
    S_INIT_LO,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [15:0]      cnt, cnt_next;
  logic [7:0]       lfsr, lfsr_next;
  logic [LANES-1:0] model, model_next;
  logic             d_reg, d_next;
  logic             en_reg, en_next;
  logic [7:0]       err_count_next;
  logic [LANES-1:0] err_lane_next;
  logic [9:0]       vec_idx_next;
  logic [LANES-1:0] q_cmp, qn_cmp;
  logic [LANES-1:0] mismatch;

  assign lat.D  = d_reg;
  assign lat.en = en_reg;

`ifdef LATCH_CHK_SYNC_EN
  logic [LANES-1:0] q_meta, q_sync, qn_meta, qn_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_meta  <= '0;
      q_sync  <= '0;
      qn_meta <= '1;
      qn_sync <= '1;
    end else begin
      q_meta  <= lat.Q;
      q_sync  <= q_meta;
      qn_meta <= lat.Q_n;
      qn_sync <= qn_meta;
    end
  end

  assign q_cmp  = q_sync;
  assign qn_cmp = qn_sync;
`else
  assign q_cmp  = lat.Q;
  assign qn_cmp = lat.Q_n;
`endif

  // A lane fails if either output disagrees with the model; Q==Q_n therefore
  // always fails, since one of the two must then be wrong.
  assign mismatch = (q_cmp ^ model) | (qn_cmp ^ ~model);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    lfsr_next      = lfsr;
    model_next     = model;
    d_next         = d_reg;
    en_next        = en_reg;
    err_count_next = err_count;
    err_lane_next  = err_lane;
    vec_idx_next   = vec_idx;

    case (state)
      S_IDLE, S_DONE: begin
        // Starting a run clears all results of the previous one.
        if (start) begin
          state_next     = S_INIT_HI;
          cnt_next       = '0;
          lfsr_next      = SEED_EFF;
          err_count_next = '0;
          err_lane_next  = '0;
          vec_idx_next   = '0;
          d_next         = 1'b0;
          en_next        = 1'b1;
        end
      end

      S_INIT_HI: begin
        // Positive-level lanes are loading 0; next, open the negative ones.
        if (cnt == SETTLE_END) begin
          state_next = S_INIT_LO;
          cnt_next   = '0;
          en_next    = 1'b0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      S_INIT_LO: begin
        if (cnt == SETTLE_END) begin
          state_next = S_APPLY;
          cnt_next   = '0;
          model_next = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      S_APPLY: begin
        // The model updates on the same edge that launches D/en, so it tracks
        // what each lane sees once it has settled.
        d_next  = lfsr[0];
        en_next = lfsr[1];
        for (int i = 0; i < LANES; i++) begin
          if (lfsr[1] ^ NEG_MASK[i]) begin
            model_next[i] = lfsr[0];
          end
        end
        lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        state_next = S_WAIT;
        cnt_next   = '0;
      end

      S_WAIT: begin
        if (cnt == WAIT_END) begin
          state_next = S_CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      S_CHECK: begin
        if (|mismatch) begin
          if (err_count != 8'hFF) begin
            err_count_next = err_count + 8'd1;
          end
          err_lane_next = err_lane | mismatch;
        end
        if (vec_idx == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          vec_idx_next = vec_idx + 10'd1;
          state_next   = S_APPLY;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      lfsr      <= SEED_EFF;
      model     <= '0;
      d_reg     <= 1'b0;
      en_reg    <= 1'b1;
      err_count <= '0;
      err_lane  <= '0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      lfsr      <= lfsr_next;
      model     <= model_next;
      d_reg     <= d_next;
      en_reg    <= en_next;
      err_count <= err_count_next;
      err_lane  <= err_lane_next;
      vec_idx   <= vec_idx_next;
      busy      <= (state == S_INIT_HI) || (state == S_INIT_LO) ||
                   (state == S_APPLY)   || (state == S_WAIT)    ||
                   (state == S_CHECK);
      done      <= (state == S_DONE);
      pass      <= (state == S_DONE) && (err_count == 8'h00);
    end
  end

endmodule

// File: tb/tb_latch_checker.sv
// tb_latch_checker
//   Directed bench for latch_checker. Two checker instances share clk/rst_n:
//   dut_a uses the default parameters, dut_b runs 300 vectors against lanes
//   whose outputs are all inverted. Behavioural latches stand in for the
//   cells; lanes 0-1 are positive-level, lanes 2-3 negative-level, and a mode
//   variable plants stuck-at or tied-output faults on dut_a's lanes.
//   Expected counts were worked out by hand from the LFSR sequence starting
//   at 8'hA5 (lane 1 holds 1 on vectors 6, 7, 10, 11 and 14).
module tb_latch_checker;

  localparam logic [3:0] NEG = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode_a = 2'd0;

  logic       busy_a, done_a, pass_a;
  logic [7:0] err_count_a;
  logic [3:0] err_lane_a;
  logic [9:0] vec_idx_a;

  logic       busy_b, done_b, pass_b;
  logic [7:0] err_count_b;
  logic [3:0] err_lane_b;
  logic [9:0] vec_idx_b;

  logic [3:0] lat_a = 4'b0000;
  logic [3:0] lat_b = 4'b0000;

  int tests_run = 0;
  int tests_failed = 0;

  latch_checker_if #(.LANES(4)) bus_a ();
  latch_checker_if #(.LANES(4)) bus_b ();

  latch_checker dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .lat       (bus_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .err_count (err_count_a),
    .err_lane  (err_lane_a),
    .vec_idx   (vec_idx_a)
  );

  latch_checker #(.NUM_VECTORS(300)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .lat       (bus_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .err_count (err_count_b),
    .err_lane  (err_lane_b),
    .vec_idx   (vec_idx_b)
  );

  always #5 clk = ~clk;

  // Behavioural gated D-latches: a lane follows D while en differs from its
  // negative-level bit, otherwise it holds.
  always @(bus_a.D or bus_a.en) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_a.en ^ NEG[i]) lat_a[i] = bus_a.D;
    end
  end

  always @(bus_b.D or bus_b.en) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_b.en ^ NEG[i]) lat_b[i] = bus_b.D;
    end
  end

  // Fault injection on dut_a's lanes: 1 = lane 1 stuck (Q=0, Q_n=1),
  // 2 = lane 0 Q_n tied to Q.
  always_comb begin
    bus_a.Q   = lat_a;
    bus_a.Q_n = ~lat_a;
    case (mode_a)
      2'd1: begin
        bus_a.Q[1]   = 1'b0;
        bus_a.Q_n[1] = 1'b1;
      end
      2'd2: begin
        bus_a.Q_n[0] = lat_a[0];
      end
      default: ;
    endcase
  end

  assign bus_b.Q   = ~lat_b;
  assign bus_b.Q_n = lat_b;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start on one checker and counts cycles until its done rises.
  // poke_cycle > 0 raises start again for one cycle mid-run.
  task automatic run_vectors(input bit use_b, input int poke_cycle, input int limit,
                             output int cycles, output logic busy_first,
                             output logic [7:0] err_first);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    err_first  = use_b ? err_count_b : err_count_a;
    cycles     = 0;
    busy_first = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) busy_first = use_b ? busy_b : busy_a;
      if (poke_cycle > 0 && !use_b) start_a = (cycles == poke_cycle);
    end while (!(use_b ? done_b : done_a) && cycles < limit);
    start_a = 1'b0;
  endtask

  int         cycles;
  int         n;
  logic       busy_first;
  logic [7:0] err_first;

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_D", 32'(bus_a.D), 32'd0);
    check_output("reset_en", 32'(bus_a.en), 32'd1);
    check_output("reset_busy", 32'(busy_a), 32'd0);
    check_output("reset_done", 32'(done_a), 32'd0);
    check_output("reset_pass", 32'(pass_a), 32'd0);
    check_output("reset_err_count", 32'(err_count_a), 32'd0);
    check_output("reset_err_lane", 32'(err_lane_a), 32'd0);
    check_output("reset_vec_idx", 32'(vec_idx_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Healthy lanes.
    mode_a = 2'd0;
    run_vectors(1'b0, 0, 500, cycles, busy_first, err_first);
    check_output("good_busy_next", 32'(busy_first), 32'd1);
    check_output("good_latency", 32'(cycles), 32'd69);
    check_output("good_done", 32'(done_a), 32'd1);
    check_output("good_pass", 32'(pass_a), 32'd1);
    check_output("good_err_count", 32'(err_count_a), 32'd0);
    check_output("good_err_lane", 32'(err_lane_a), 32'd0);
    check_output("good_vec_idx", 32'(vec_idx_a), 32'd15);

    // Lane 1 stuck: fails on the five vectors where that lane should hold 1.
    mode_a = 2'd1;
    run_vectors(1'b0, 0, 500, cycles, busy_first, err_first);
    check_output("stuck_latency", 32'(cycles), 32'd69);
    check_output("stuck_err_count", 32'(err_count_a), 32'd5);
    check_output("stuck_err_lane", 32'(err_lane_a), 32'b0010);
    check_output("stuck_pass", 32'(pass_a), 32'd0);

    // Lane 0 Q tied to Q_n: every vector fails.
    mode_a = 2'd2;
    run_vectors(1'b0, 0, 500, cycles, busy_first, err_first);
    check_output("tied_err_count", 32'(err_count_a), 32'd16);
    check_output("tied_err_lane", 32'(err_lane_a), 32'b0001);
    check_output("tied_pass", 32'(pass_a), 32'd0);

    // Restart from DONE clears results; a start mid-run is ignored.
    mode_a = 2'd0;
    run_vectors(1'b0, 20, 500, cycles, busy_first, err_first);
    check_output("restart_err_cleared", 32'(err_first), 32'd0);
    check_output("restart_ignore_latency", 32'(cycles), 32'd69);
    check_output("restart_pass", 32'(pass_a), 32'd1);
    check_output("restart_err_count", 32'(err_count_a), 32'd0);

    // Abort with reset during vector 7.
    mode_a = 2'd1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n = 0;
    while (vec_idx_a != 10'd7 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("abort_reached_vec7", 32'(vec_idx_a), 32'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_busy", 32'(busy_a), 32'd0);
    check_output("abort_done", 32'(done_a), 32'd0);
    check_output("abort_D", 32'(bus_a.D), 32'd0);
    check_output("abort_en", 32'(bus_a.en), 32'd1);
    check_output("abort_vec_idx", 32'(vec_idx_a), 32'd0);
    check_output("abort_err_count", 32'(err_count_a), 32'd0);
    check_output("abort_err_lane", 32'(err_lane_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A fresh run after the abort behaves like the first one.
    mode_a = 2'd0;
    run_vectors(1'b0, 0, 500, cycles, busy_first, err_first);
    check_output("post_abort_latency", 32'(cycles), 32'd69);
    check_output("post_abort_pass", 32'(pass_a), 32'd1);

    // 300 vectors, all lanes inverted: count saturates.
    run_vectors(1'b1, 0, 3000, cycles, busy_first, err_first);
    check_output("sat_latency", 32'(cycles), 32'd1205);
    check_output("sat_err_count", 32'(err_count_b), 32'd255);
    check_output("sat_err_lane", 32'(err_lane_b), 32'b1111);
    check_output("sat_pass", 32'(pass_b), 32'd0);
    check_output("sat_vec_idx", 32'(vec_idx_b), 32'd299);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
